// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first,
// with a start/done handshake and carry-out / signed-overflow flags.
module serial_addsub #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             co,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic             r_co;
  logic             r_ovf;

  logic             w_s;
  logic             w_cnext;
  logic             w_last;

  always_comb begin
    w_s     = r_a[0] ^ r_b[0] ^ r_c;
    w_cnext = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    w_last  = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_co    <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_c     <= sub;
            r_cnt   <= '0;
            r_res   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res <= {w_s, r_res[WIDTH-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_c   <= w_cnext;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // r_c here is the carry into the MSB; its XOR with carry-out flags signed overflow.
            r_co    <= w_cnext;
            r_ovf   <= r_c ^ w_cnext;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign r    = r_res;
  assign co   = r_co;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: arithmetic reference model with a
// per-cycle compare, plus directed vectors with hand-computed results.
module tb_serial_addsub;

  localparam int unsigned W = 16;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] r;
  logic         co;
  logic         ovf;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  bit          chk_en = 1'b0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .r     (r),
    .co    (co),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference result from plain integer arithmetic: {ovf, co, r}.
  function automatic logic [W+1:0] golden(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic s);
    longint       ux     = longint'(x);
    longint       uy     = longint'(y);
    longint       sx     = longint'($signed(x));
    longint       sy     = longint'($signed(y));
    longint       full_u = s ? ux - uy : ux + uy;
    longint       full_s = s ? sx - sy : sx + sy;
    longint       lim    = longint'(1) << (W - 1);
    logic [W-1:0] res    = full_u[W-1:0];
    logic         c      = s ? (ux >= uy) : (full_u >= (longint'(1) << W));
    logic         v      = (full_s >= lim) || (full_s < -lim);
    return {v, c, res};
  endfunction

  // Cycle-level behaviour: busy for W cycles after acceptance, one done cycle,
  // outputs published on done and held otherwise.
  logic         m_busy, m_done, m_co, m_ovf;
  logic [W-1:0] m_r;
  logic [W+1:0] m_pend;
  int           m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_r    <= '0;
      m_co   <= 1'b0;
      m_ovf  <= 1'b0;
      m_pend <= '0;
      m_left <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_r    <= m_pend[W-1:0];
        m_co   <= m_pend[W];
        m_ovf  <= m_pend[W+1];
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (start) begin
      m_pend <= golden(a, b, sub);
      m_busy <= 1'b1;
      m_left <= W;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", 32'(busy), 32'(m_busy));
      check("cyc_done", 32'(done), 32'(m_done));
      check("cyc_busy_done_excl", 32'(busy & done), 32'd0);
      if (!m_busy) begin
        check("cyc_r", 32'(r), 32'(m_r));
        check("cyc_co", 32'(co), 32'(m_co));
        check("cyc_ovf", 32'(ovf), 32'(m_ovf));
      end
    end
  end

  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic ts, input logic [W-1:0] er, input logic eco,
                        input logic eovf);
    int unsigned cyc   = 0;
    int unsigned nbusy = 0;
    @(negedge clk);
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta; b = ~tb; sub = ~ts;
    if (busy) nbusy++;
    while (!done && cyc < 4 * W) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) nbusy++;
    end
    check({nm, "_latency"}, cyc, W);
    check({nm, "_busy_cycles"}, nbusy, W);
    check({nm, "_r"}, 32'(r), 32'(er));
    check({nm, "_co"}, 32'(co), 32'(eco));
    check({nm, "_ovf"}, 32'(ovf), 32'(eovf));
    @(posedge clk);
    #1;
    check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned nd;
    int          edge_n;
    int          last;
    int          pulses;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_r", 32'(r), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_op("add_basic",  16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);
    run_op("add_wrap",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_equal",  16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Reset in mid-operation: co=1 from the previous result must clear at once.
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("abort_busy_before", 32'(busy), 32'd1);
    check("abort_co_held", 32'(co), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_r", 32'(r), 32'd0);
    check("abort_co", 32'(co), 32'd0);
    check("abort_ovf", 32'(ovf), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    repeat (2 * W) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);
    run_op("post_reset", 16'h0002, 16'h0003, 1'b0, 16'h0005, 1'b0, 1'b0);

    // start during RUN and during DONE must be ignored.
    @(negedge clk);
    a = 16'h0010; b = 16'h0020; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    repeat (3) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    start = 1'b0;
    while (!done && cyc < 4 * W) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("ign_latency", cyc, W);
    check("ign_r", 32'(r), 32'h0030);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_done_drop", 32'(done), 32'd0);
    check("ign_not_busy", 32'(busy), 32'd0);
    nd = 0;
    repeat (2 * W) begin
      @(posedge clk);
      #1;
      if (done) nd++;
    end
    check("ign_no_second_done", nd, 0);
    check("ign_r_held", 32'(r), 32'h0030);

    // start held high: one operation every W+2 cycles.
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    edge_n = 0;
    last   = -1;
    pulses = 0;
    while (pulses < 3 && edge_n < 6 * (W + 2)) begin
      @(posedge clk);
      #1;
      edge_n++;
      if (done) begin
        check("b2b_r", 32'(r), 32'h0002);
        if (last >= 0) check("b2b_spacing", 32'(edge_n - last), W + 2);
        last = edge_n;
        pulses++;
      end
    end
    start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd3);
    @(posedge clk);
    #1;
    repeat (2) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
